// File: rtl/mpadd_seq_if.sv
// Limb streams of the multi-precision add sequencer: operand pairs in, sum limbs out.
// The master side drives operands and consumes sums; the slave side is the sequencer.
interface mpadd_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_word;
  logic [31:0] b_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s_word;
  logic        s_last;

  modport master (
    output in_valid, a_word, b_word, out_ready,
    input  in_ready, out_valid, s_word, s_last
  );

  modport slave (
    input  in_valid, a_word, b_word, out_ready,
    output in_ready, out_valid, s_word, s_last
  );
endinterface

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: WORDS 32-bit limbs, LS limb first, carry chained in a register.
// Optional signed-overflow output ovf is enabled by defining MPADD_SEQ_OVF_EN.
module mpadd_seq #(
  parameter int WORDS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic sub,
  output logic busy,
  output logic done,
  output logic cout,
`ifdef MPADD_SEQ_OVF_EN
  output logic ovf,
`endif
  mpadd_seq_if.slave bus
);

  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  state_t      state_next;
  logic        op_sub;
  logic        carry;
  logic [CW-1:0] cnt;
  logic [31:0] s_reg;
  logic        s_last_reg;
  logic        out_valid_reg;
  logic        in_ready_int;
  logic        in_fire;
  logic        out_fire;
  logic        start_ok;
  logic [31:0] b_eff;
  logic [32:0] sum;

  assign start_ok = start && (state == IDLE);
  assign in_fire  = bus.in_valid && in_ready_int;
  assign out_fire = out_valid_reg && bus.out_ready;

  // Subtraction is a + ~b + 1; the +1 comes from the carry seeded with op_sub at start.
  assign b_eff = op_sub ? ~bus.b_word : bus.b_word;
  assign sum   = {1'b0, bus.a_word} + {1'b0, b_eff} + 33'(carry);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (in_fire && (cnt == LAST)) state_next = DRAIN;
      DRAIN:   if (out_fire && s_last_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The single output register may be refilled in the same cycle it is drained.
  always_comb begin
    busy         = (state != IDLE);
    in_ready_int = (state == RUN) && (!out_valid_reg || bus.out_ready);
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.s_word    = s_reg;
  assign bus.s_last    = s_last_reg;

`ifdef MPADD_SEQ_OVF_EN
  logic ovf_top;

  // Overflow is carry-in XOR carry-out of bit 31; the last loaded limb is the top one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_top <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (in_fire)
        ovf_top <= bus.a_word[31] ^ b_eff[31] ^ sum[31] ^ sum[32];
      if (out_fire && s_last_reg)
        ovf <= ovf_top;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      op_sub        <= 1'b0;
      carry         <= 1'b0;
      cnt           <= '0;
      s_reg         <= '0;
      s_last_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      done          <= 1'b0;
      cout          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        op_sub <= sub;
        carry  <= sub;
        cnt    <= '0;
      end
      if (in_fire) begin
        s_reg         <= sum[31:0];
        carry         <= sum[32];
        out_valid_reg <= 1'b1;
        s_last_reg    <= (cnt == LAST);
        cnt           <= cnt + 1'b1;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
      if (out_fire && s_last_reg) begin
        done <= 1'b1;
        cout <= op_sub ? ~carry : carry;
      end
    end
  end

endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq: add/sub vectors, backpressure, reset mid-operation, ignored start.
// Define MPADD_SEQ_OVF_EN for both files to also check the overflow output.
module tb_mpadd_seq;

  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sub;
  logic busy;
  logic done;
  logic cout;
`ifdef MPADD_SEQ_OVF_EN
  logic ovf;
`endif

  int checks = 0;
  int errors = 0;

  mpadd_seq_if bus ();

  mpadd_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .cout  (cout),
`ifdef MPADD_SEQ_OVF_EN
    .ovf   (ovf),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_s_word"}, bus.s_word, 32'd0);
    check({tag, "_s_last"}, 32'(bus.s_last), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'd0);
`ifdef MPADD_SEQ_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  // Runs one operation from a negedge; all expectations are passed in as hand-computed constants.
  task automatic run_op(input string tag, input logic op, input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                        input int stall, input int ign_start_at, input int exp_done_cycle);
    int  in_idx = 0;
    int  out_idx = 0;
    int  stall_left = stall;
    int  done_cycle = -1;
    bit  seen_done = 1'b0;
    bit  stalled;
    sub   = op;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (i == ign_start_at) begin
        start = 1'b1;
        sub   = ~op;
      end else begin
        start = 1'b0;
        sub   = op;
      end
      if (done) begin
        seen_done  = 1'b1;
        done_cycle = i;
      end else begin
        stalled = 1'b0;
        if (bus.out_valid && stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
          stalled = 1'b1;
        end else begin
          bus.out_ready = 1'b1;
        end
        if (in_idx < WORDS) begin
          bus.in_valid = 1'b1;
          bus.a_word   = a[in_idx*32 +: 32];
          bus.b_word   = b[in_idx*32 +: 32];
        end else begin
          bus.in_valid = 1'b0;
          bus.a_word   = 32'd0;
          bus.b_word   = 32'd0;
        end
        #1;
        if (stalled) begin
          check({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
          check({tag, "_stall_s_word"}, bus.s_word, exp_sum[out_idx*32 +: 32]);
        end
        if (bus.out_valid && bus.out_ready && out_idx < WORDS) begin
          check({tag, "_limb"}, bus.s_word, exp_sum[out_idx*32 +: 32]);
          check({tag, "_s_last"}, 32'(bus.s_last), 32'(out_idx == WORDS - 1));
          out_idx++;
        end
        if (bus.in_valid && bus.in_ready) in_idx++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    start        = 1'b0;
    sub          = 1'b0;
    bus.in_valid = 1'b0;
    check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
    check({tag, "_done_cycle"}, 32'(done_cycle), 32'(exp_done_cycle));
    check({tag, "_limb_count"}, 32'(out_idx), 32'(WORDS));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef MPADD_SEQ_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf) $display("[TB] %s: overflow expected but output not built", tag);
`endif
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    check({tag, "_cout_hold"}, 32'(cout), 32'(exp_cout));
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    sub           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_word    = 32'd0;
    bus.b_word    = 32'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    $display("[TB] add carry across limb 0");
    run_op("add_carry", 1'b0, 128'h00000000_00000000_00000000_FFFFFFFF, 128'h1,
           128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0, 0, -1, 5);

    $display("[TB] add all ones");
    run_op("add_ones", 1'b0, {128{1'b1}}, {128{1'b1}},
           128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b1, 1'b0, 0, -1, 5);

    $display("[TB] subtract with borrow");
    run_op("sub_borrow", 1'b1, 128'h1, 128'h2,
           {128{1'b1}}, 1'b1, 1'b0, 0, -1, 5);

    $display("[TB] subtract equal operands");
    run_op("sub_equal", 1'b1, 128'h5, 128'h5, 128'h0, 1'b0, 1'b0, 0, -1, 5);

    $display("[TB] backpressure after first limb");
    run_op("stall", 1'b0, 128'h00000000_00000000_00000000_FFFFFFFF, 128'h1,
           128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0, 3, -1, 8);

    $display("[TB] reset mid-operation");
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start         = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) begin
      bus.in_valid = 1'b1;
      bus.a_word   = 32'hFFFFFFFF;
      bus.b_word   = 32'hFFFFFFFF;
      @(posedge clk);
      @(negedge clk);
    end
    check("midrst_out_valid_before", 32'(bus.out_valid), 32'd1);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("midrst");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    run_op("after_rst", 1'b0, 128'h00000000_00000000_00000000_FFFFFFFF, 128'h1,
           128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0, 0, -1, 5);

    $display("[TB] ignored start during RUN");
    run_op("ign_start", 1'b0, {128{1'b1}}, {128{1'b1}},
           128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b1, 1'b0, 0, 1, 5);

    $display("[TB] signed overflow in top limb");
    run_op("ovf", 1'b0, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1,
           128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1, 0, -1, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpadd_seq.md
Name: mpadd_seq

Overview:
- Multi-precision add/subtract sequencer built around a single shared 32-bit add datapath (a + b + cin, combinational).
- An operation spans WORDS 32-bit limbs. Limb pairs arrive least-significant first over a valid/ready stream; sum limbs leave over a valid/ready stream.
- The block chains the carry between limbs in a register and reports the final carry-out, or borrow for subtraction.
- Sits between a wide-operand source, such as a register file or bignum unit, and the existing 32-bit carry-select adder.

Parameters:
- WORDS, 4, number of 32-bit limbs per operation (legal range 2..16).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins an operation; accepted only in IDLE.
- sub  input  1  operation select, sampled with start: 0 = add (a+b), 1 = subtract (a-b).
- busy  output  1  high from the cycle after an accepted start until the return to IDLE.
- in_valid  input  1  limb pair valid.
- in_ready  output  1  limb pair accepted when in_valid && in_ready.
- a_word  input  32  operand A limb.
- b_word  input  32  operand B limb.
- out_valid  output  1  sum limb valid.
- out_ready  input  1  consumer accepts the sum limb.
- s_word  output  32  sum limb.
- s_last  output  1  marks the most-significant (WORDS-th) sum limb.
- done  output  1  one-cycle pulse when the last limb is accepted downstream.
- cout  output  1  final carry (add) or borrow (sub); valid from done until the next accepted start.

Behaviour:
- Reset (rst=1 at a clock edge) sets: state=IDLE, busy=0, in_ready=0, out_valid=0, s_word=0, s_last=0, done=0, cout=0, limb counter=0, carry register=0.
- reset mid-operation: the same values apply, the partial result is discarded, and no done is issued.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when the WORDS-th input limb is accepted.
  - DRAIN -> IDLE when the last output limb is accepted.
- start in RUN or DRAIN is ignored.
- On an accepted start:
  - latch sub into op_sub.
  - carry register := op_sub (cin=1 for two's-complement subtract).
  - limb counter := 0.
- Datapath per accepted limb:
  - b_eff = op_sub ? ~b_word : b_word.
  - {c, s} = a_word + b_eff + carry, a 33-bit result.
  - s_word <= s; carry <= c; out_valid <= 1; s_last <= (counter == WORDS-1); counter increments.
- in_ready = (state==RUN) && (!out_valid || out_ready).
  - The output stage is a single register; simultaneous accept-out and accept-in in the same cycle is allowed, so throughput is 1 limb per cycle.
  - Latency from input accept to out_valid is 1 cycle.
- Output handshake:
  - s_word, s_last and out_valid hold stable while out_valid && !out_ready.
  - out_valid clears on accept unless a new limb loads in the same cycle.
- Final result:
  - On acceptance of the s_last limb: done pulses for 1 cycle, state -> IDLE.
  - cout := carry for add, or ~carry for sub (borrow = 1 when a < b unsigned).
- busy deasserts in the same cycle done pulses.
- in_valid in IDLE/DRAIN has no effect; in_ready is 0 in those states.
- Counter width is clog2(WORDS); the counter wraps only via reset or a new start.

Optional Feature:
- Macro MPADD_SEQ_OVF_EN.
- When defined:
  - adds output port ovf (1 bit), the signed two's-complement overflow of the full WORDS*32-bit operation.
  - ovf = carry into bit 31 of the top limb XOR carry out of bit 31 of the top limb.
  - ovf is registered with the same timing and hold rules as cout; it is 0 on reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WORDS=4, add, A=0x00000000_00000000_00000000_FFFFFFFF, B=1, no backpressure:
  - sum limbs 0x00000000, 0x00000001, 0x00000000, 0x00000000 on consecutive cycles.
  - s_last on limb 3; done with cout=0; 4 limbs in 4 cycles.
- Add with A=B=all-ones (128-bit):
  - limbs 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF.
  - cout=1; with the OVF macro, ovf=0.
- Subtract A=1, B=2 (128-bit):
  - all limbs 0xFFFFFFFF; cout(borrow)=1.
  - Subtract A=5, B=5 gives all zero limbs and cout=0.
- Backpressure: hold out_ready=0 for 3 cycles after the first limb.
  - in_ready=0 while stalled; s_word stable.
  - The result is identical to the unstalled run; done occurs 3 cycles later.
- Reset mid-operation: assert rst after 2 limbs.
  - All outputs return to reset values next edge; no done pulse.
  - A following start/add runs correctly with carry=0.
- Ignored start: pulse start with sub=1 during RUN of an add.
  - The add result is unchanged; op_sub stays 0.
  - With the OVF macro: 0x7FFFFFFF... + 1 top limb gives ovf=1.
